utm_tape_controller: RTL and testbench
======================================

# utm_tape_controller

Sequential driver for the Turing-machine transition-rule block: holds the tape, head position and current state, presents (state, symbol) to the rule logic each step, and commits the returned new symbol, head move and next state. It is the initiator side of the rule interface (dense 3-bit state, 3-bit symbol, 1-bit direction), so the combinational rule block runs a complete program on-chip without an external host stepping it.

## Interface
Parameters:
- TAPE_LEN, 16: tape cells; head index width is clog2(TAPE_LEN).
- HALT_STATE, 3'd7: encoded state that stops execution.
- STEP_LIMIT, 16'hFFFF: maximum committed steps before forced stop.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write load_sym into tape[load_addr]; ignored while busy.
- load_addr  in  4  tape index for load/readback.
- load_sym  in  3  symbol to preload.
- rd_sym  out  3  combinational tape[load_addr].
- start  in  1  begin run; sampled only in IDLE or DONE.
- start_state  in  3  initial machine state.
- start_head  in  4  initial head index.
- rule_valid  out  1  high while rule_state/rule_sym are presented.
- rule_state  out  3  current state to rule block.
- rule_sym  out  3  tape[head] to rule block.
- rule_next_state  in  3  next state from rule block.
- rule_new_sym  in  3  symbol to write at head.
- rule_dir  in  1  1 = head+1 (right), 0 = head-1 (left).
- busy  out  1  high in FETCH/COMMIT.
- done  out  1  high in DONE.
- fault  out  1  head attempted to leave the tape.
- timeout  out  1  STEP_LIMIT reached without halting.
- head  out  4  current head index.
- state  out  3  current machine state.
- step_count  out  16  committed steps in current run.

## Operation
- FSM states: IDLE, FETCH, COMMIT, DONE.
- IDLE/DONE + start: state<=start_state, head<=start_head, step_count<=0, fault<=0, timeout<=0; go FETCH, except start_state==HALT_STATE or start_head>=TAPE_LEN -> DONE directly (latter sets fault).
- FETCH: rule_valid=1, rule_state=state, rule_sym=tape[head]; -> COMMIT.
- COMMIT: outputs held identical to FETCH; at the closing edge sample rule_* and: tape[head]<=rule_new_sym, state<=rule_next_state, step_count+1.
  - Head move: dir=1 and head==TAPE_LEN-1, or dir=0 and head==0 -> head unchanged, fault<=1, -> DONE (symbol and state still committed).
  - Otherwise head+/-1; then rule_next_state==HALT_STATE -> DONE; else step_count+1==STEP_LIMIT -> timeout<=1, DONE; else FETCH.
  - Priority when simultaneous: fault > halt > timeout.
- DONE: holds tape, state, head, step_count, flags until next start.
- load_en acts in IDLE and DONE only; in FETCH/COMMIT it is ignored. load_en and start in the same cycle: load applies first, run sees the loaded cell.
- No wrap-around of head or step_count.

## Timing
- Reset (async assert, sync-safe deassert): FSM IDLE; all tape cells 0; state 0, head 0, step_count 0; rule_valid, busy, done, fault, timeout 0; rule_state 0, rule_sym = tape[0] = 0.
- Each step is exactly 2 cycles; rule block has one full cycle (COMMIT) of settle after rule_valid rises.
- Run halting after N steps: start sampled at edge E0; done=1 after edge E0+2N; busy=1 from E0 to E0+2N.
- start with HALT_STATE: done=1 after E0, step_count 0.
- Reset asserted mid-run: immediate return to reset values; tape contents lost.
- rd_sym reflects a tape write in the cycle after the committing edge.

## Test plan
- Reset: pulse reset_n low mid-cycle -> all outputs 0 immediately; rd_sym=0 for every load_addr 0..15.
- Preload/readback: load cells 0..15 with addr%8, then sweep load_addr -> rd_sym matches; load_en during busy -> cell unchanged.
- Run with stub rule (state s, sym x -> next s+1, write x+1, right), start_state 0, head 2, tape 0 -> halts at state 7 after 7 steps: done after 14 edges, step_count 7, head 9, cells 2..8 = 1, fault 0.
- Left edge: head 0, rule always dir=0, next state 1 -> after 1 step DONE, fault 1, head 0, tape[0]=new sym, step_count 1.
- Timeout: STEP_LIMIT=5, rule never halts and bounces direction -> done, timeout 1, step_count 5, after 10 edges.
- start_state=7 -> done after 1 edge, step_count 0, rule_valid never asserted; restart from DONE with state 0 runs normally on retained tape.

Source files
------------

// File: rtl/utm_tape_controller.sv
// -----------------------------------------------------------------------------
// utm_tape_controller
//
// Sequential driver for a combinational Turing-machine transition-rule block.
// It holds the tape, the head position and the current machine state. Each
// step it presents (state, symbol under head) to the rule block, gives the
// rule block one full cycle to settle, then commits the returned symbol,
// head move and next state. A run ends on the halt state, on the head trying
// to leave the tape (fault), or on reaching the step limit (timeout).
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   load_en/load_addr/load_sym preload one tape cell (only while not busy)
//   rd_sym                    combinational readback of tape[load_addr]
//   start/start_state/start_head  begin a run (sampled in IDLE or DONE)
//   rule_valid/rule_state/rule_sym  request to the rule block
//   rule_next_state/rule_new_sym/rule_dir  response from the rule block
//   busy, done, fault, timeout  run status
//   head, state, step_count   architectural machine state
// -----------------------------------------------------------------------------
module utm_tape_controller #(
    parameter int          TAPE_LEN   = 16,
    parameter logic [2:0]  HALT_STATE = 3'd7,
    parameter logic [15:0] STEP_LIMIT = 16'hFFFF,
    localparam int         HW         = (TAPE_LEN > 1) ? $clog2(TAPE_LEN) : 1
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          load_en,
    input  logic [HW-1:0] load_addr,
    input  logic [2:0]    load_sym,
    output logic [2:0]    rd_sym,

    input  logic          start,
    input  logic [2:0]    start_state,
    input  logic [HW-1:0] start_head,

    output logic          rule_valid,
    output logic [2:0]    rule_state,
    output logic [2:0]    rule_sym,
    input  logic [2:0]    rule_next_state,
    input  logic [2:0]    rule_new_sym,
    input  logic          rule_dir,

    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic          timeout,
    output logic [HW-1:0] head,
    output logic [2:0]    state,
    output logic [15:0]   step_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_COMMIT,
        S_DONE
    } ctrl_e;

    localparam logic [HW-1:0] HEAD_LAST  = HW'(TAPE_LEN - 1);
    localparam logic [HW-1:0] HEAD_ONE   = HW'(1);
    localparam logic [HW:0]   TAPE_LEN_X = (HW + 1)'(TAPE_LEN);

    ctrl_e       fsm, fsm_next;
    logic [2:0]  tape [TAPE_LEN];

    logic        accept_start;
    logic        start_bad;
    logic        load_ok;
    logic        edge_hit;
    logic        halt_hit;
    logic        limit_hit;
    logic [15:0] step_inc;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    // Start head is widened by one bit so the range check is meaningful
    // even when TAPE_LEN is not a power of two.
    assign start_bad = {1'b0, start_head} >= TAPE_LEN_X;
    assign step_inc  = step_count + 16'd1;
    // Moving off either end of the tape is detected before the move.
    assign edge_hit  = rule_dir ? (head == HEAD_LAST) : (head == '0);
    assign halt_hit  = (rule_next_state == HALT_STATE);
    assign limit_hit = (step_inc == STEP_LIMIT);

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            fsm <= fsm_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        fsm_next     = fsm;
        accept_start = 1'b0;
        case (fsm)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    if (start_state == HALT_STATE || start_bad) begin
                        fsm_next = S_DONE;
                    end else begin
                        fsm_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                fsm_next = S_COMMIT;
            end
            S_COMMIT: begin
                if (edge_hit || halt_hit || limit_hit) begin
                    fsm_next = S_DONE;
                end else begin
                    fsm_next = S_FETCH;
                end
            end
            default: begin
                fsm_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status and rule-interface outputs
    // ------------------------------------------------------------------
    assign busy       = (fsm == S_FETCH) || (fsm == S_COMMIT);
    assign rule_valid = busy;
    assign done       = (fsm == S_DONE);
    assign rule_state = state;
    // Presented continuously; stable through FETCH and COMMIT because the
    // tape and head only change at the closing edge of COMMIT.
    assign rule_sym   = tape[head];
    assign rd_sym     = tape[load_addr];
    assign load_ok    = load_en && !busy;

    // ------------------------------------------------------------------
    // Tape storage
    // ------------------------------------------------------------------
    // Loads and commits are mutually exclusive in time (idle/done vs
    // commit), so a single write port suffices.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the tape is cleared on reset because a run after reset
            // must see all-zero cells; this keeps it in flops, not RAM.
            for (int i = 0; i < TAPE_LEN; i++) begin
                tape[i] <= '0;
            end
        end else if (load_ok) begin
            tape[load_addr] <= load_sym;
        end else if (fsm == S_COMMIT) begin
            tape[head] <= rule_new_sym;
        end
    end

    // ------------------------------------------------------------------
    // Machine state, head, step counter and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= '0;
            head       <= '0;
            step_count <= '0;
            fault      <= 1'b0;
            timeout    <= 1'b0;
        end else if (accept_start) begin
            state      <= start_state;
            head       <= start_head;
            step_count <= '0;
            fault      <= start_bad;
            timeout    <= 1'b0;
        end else if (fsm == S_COMMIT) begin
            // Symbol and state are committed even when the move faults.
            state      <= rule_next_state;
            step_count <= step_inc;
            if (edge_hit) begin
                fault <= 1'b1;
            end else begin
                head <= rule_dir ? (head + HEAD_ONE) : (head - HEAD_ONE);
                // Fault outranks halt, halt outranks timeout.
                if (!halt_hit && limit_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_utm_tape_controller.sv
// -----------------------------------------------------------------------------
// tb_utm_tape_controller
//
// Self-checking bench for utm_tape_controller. A small combinational rule
// block is modelled here (stub, left-walker, bouncer, random table). The
// expected results of every run come from a step-by-step machine model that
// applies the rule directly to a shadow tape.
// -----------------------------------------------------------------------------
module tb_utm_tape_controller;

    localparam int         TL   = 16;
    localparam int         LIM  = 12;
    localparam logic [2:0] HALT = 3'd7;
    localparam int         BOUND = 2 * LIM + 6;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [2:0]  load_sym = '0;
    logic [2:0]  rd_sym;
    logic        start = 1'b0;
    logic [2:0]  start_state = '0;
    logic [3:0]  start_head = '0;
    logic        rule_valid;
    logic [2:0]  rule_state;
    logic [2:0]  rule_sym;
    logic [2:0]  rule_next_state;
    logic [2:0]  rule_new_sym;
    logic        rule_dir;
    logic        busy;
    logic        done;
    logic        fault;
    logic        timeout;
    logic [3:0]  head;
    logic [2:0]  state;
    logic [15:0] step_count;

    // Rule block personality: 0 stub, 1 left walker, 2 bouncer, 3 table.
    logic [1:0]  rule_mode = 2'd0;
    logic [6:0]  rtab [64];

    // Shadow tape and model results.
    logic [2:0]  m_tape [TL];
    logic [2:0]  obs_tape [TL];
    logic [2:0]  e_state;
    logic [3:0]  e_head;
    int          e_steps;
    bit          e_fault;
    bit          e_to;

    // Run observations.
    int          r_edges;
    int          r_gap;
    bit          r_timeout;

    int          n_checks = 0;
    int          n_bad = 0;

    utm_tape_controller #(
        .TAPE_LEN   (TL),
        .HALT_STATE (HALT),
        .STEP_LIMIT (16'(LIM))
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_sym        (load_sym),
        .rd_sym          (rd_sym),
        .start           (start),
        .start_state     (start_state),
        .start_head      (start_head),
        .rule_valid      (rule_valid),
        .rule_state      (rule_state),
        .rule_sym        (rule_sym),
        .rule_next_state (rule_next_state),
        .rule_new_sym    (rule_new_sym),
        .rule_dir        (rule_dir),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .timeout         (timeout),
        .head            (head),
        .state           (state),
        .step_count      (step_count)
    );

    always #5 clock = ~clock;

    // Combinational rule block seen by the DUT.
    always_comb begin
        rule_next_state = 3'd0;
        rule_new_sym    = 3'd0;
        rule_dir        = 1'b0;
        case (rule_mode)
            2'd0: begin
                rule_next_state = rule_state + 3'd1;
                rule_new_sym    = rule_sym + 3'd1;
                rule_dir        = 1'b1;
            end
            2'd1: begin
                rule_next_state = 3'd1;
                rule_new_sym    = 3'd5;
                rule_dir        = 1'b0;
            end
            2'd2: begin
                rule_next_state = rule_state ^ 3'd1;
                rule_new_sym    = rule_sym + 3'd2;
                rule_dir        = rule_state[0];
            end
            default: begin
                {rule_next_state, rule_new_sym, rule_dir} = rtab[{rule_state, rule_sym}];
            end
        endcase
    end

    // Same rule as a function for the model: {next_state, new_sym, dir}.
    function automatic logic [6:0] rule_fn(input logic [2:0] s, input logic [2:0] x);
        case (rule_mode)
            2'd0:    return {s + 3'd1, x + 3'd1, 1'b1};
            2'd1:    return {3'd1, 3'd5, 1'b0};
            2'd2:    return {s ^ 3'd1, x + 3'd2, s[0]};
            default: return rtab[{s, x}];
        endcase
    endfunction

    function automatic logic [47:0] pack_model();
        logic [47:0] v = '0;
        for (int i = 0; i < TL; i++) v[3*i +: 3] = m_tape[i];
        return v;
    endfunction

    function automatic logic [47:0] pack_obs();
        logic [47:0] v = '0;
        for (int i = 0; i < TL; i++) v[3*i +: 3] = obs_tape[i];
        return v;
    endfunction

    // Machine model: apply the rule step by step to the shadow tape.
    task automatic model_run(input logic [2:0] ss, input logic [3:0] sh);
        logic [6:0] r;
        int h;
        e_state = ss;
        h       = int'(sh);
        e_steps = 0;
        e_fault = 1'b0;
        e_to    = 1'b0;
        if (h >= TL) begin
            e_fault = 1'b1;
        end else if (ss != HALT) begin
            forever begin
                r = rule_fn(e_state, m_tape[h]);
                m_tape[h] = r[3:1];
                e_state   = r[6:4];
                e_steps++;
                if (r[0] ? (h == TL - 1) : (h == 0)) begin
                    e_fault = 1'b1;
                    break;
                end
                h = r[0] ? h + 1 : h - 1;
                if (e_state == HALT) break;
                if (e_steps == LIM) begin
                    e_to = 1'b1;
                    break;
                end
            end
        end
        e_head = 4'(h);
    endtask

    task automatic load_cell(input logic [3:0] a, input logic [2:0] s);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = a;
        load_sym  = s;
        @(posedge clock);
        #1;
        load_en = 1'b0;
        m_tape[a] = s;
    endtask

    task automatic read_tape();
        for (int i = 0; i < TL; i++) begin
            load_addr = 4'(i);
            #1;
            obs_tape[i] = rd_sym;
        end
    endtask

    // Start a run and count edges after the start edge until done rises.
    task automatic run_dut(input logic [2:0] ss, input logic [3:0] sh,
                           input bit ld, input logic [3:0] la, input logic [2:0] ls,
                           input bit busy_ld);
        @(negedge clock);
        start       = 1'b1;
        start_state = ss;
        start_head  = sh;
        load_en     = ld;
        load_addr   = la;
        load_sym    = ls;
        @(posedge clock);
        #1;
        start   = 1'b0;
        load_en = 1'b0;
        r_edges = 0;
        r_gap   = 0;
        while (done !== 1'b1 && r_edges < BOUND) begin
            if (busy !== 1'b1 || rule_valid !== 1'b1) r_gap++;
            if (busy_ld) begin
                load_en   = (r_edges == 1);
                load_addr = 4'd14;
                load_sym  = 3'd7;
            end
            @(posedge clock);
            #1;
            r_edges++;
        end
        load_en   = 1'b0;
        r_timeout = (done !== 1'b1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [33:0] obs;
        load_cell(4'd0, 3'd3);
        load_cell(4'd9, 3'd6);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        obs = {rule_valid, busy, done, fault, timeout, state, head, step_count, rule_state, rule_sym};
        n_checks++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        read_tape();
        for (int i = 0; i < TL; i++) begin
            n_checks++;
            if (obs_tape[i] !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_cell%0d: got %0d want 0", i, obs_tape[i]);
            end
            m_tape[i] = 3'd0;
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < TL; i++) load_cell(4'(i), 3'(i % 8));
        read_tape();
        for (int i = 0; i < TL; i++) begin
            n_checks++;
            if (obs_tape[i] !== 3'(i % 8)) begin
                n_bad++;
                $display("FAIL preload_cell%0d: got %0d want %0d", i, obs_tape[i], i % 8);
            end
        end
    endtask

    task automatic test_stub_run();
        for (int i = 0; i < TL; i++) load_cell(4'(i), 3'd0);
        rule_mode = 2'd0;
        model_run(3'd0, 4'd2);
        run_dut(3'd0, 4'd2, 1'b0, 4'd0, 3'd0, 1'b1);
        n_checks++;
        if (r_timeout || r_edges !== 14 || r_gap !== 0) begin
            n_bad++;
            $display("FAIL stub_latency: got edges=%0d gap=%0d want edges=14 gap=0", r_edges, r_gap);
        end
        n_checks++;
        if ({busy, fault, timeout, state, head, step_count} !== {1'b0, 1'b0, 1'b0, 3'd7, 4'd9, 16'd7}) begin
            n_bad++;
            $display("FAIL stub_status: got busy=%0b fault=%0b to=%0b st=%0d hd=%0d steps=%0d want 0 0 0 7 9 7",
                     busy, fault, timeout, state, head, step_count);
        end
        read_tape();
        for (int i = 0; i < TL; i++) begin
            n_checks++;
            if (obs_tape[i] !== ((i >= 2 && i <= 8) ? 3'd1 : 3'd0)) begin
                n_bad++;
                $display("FAIL stub_cell%0d: got %0d want %0d", i, obs_tape[i], (i >= 2 && i <= 8) ? 1 : 0);
            end
        end
    endtask

    task automatic test_left_edge();
        rule_mode = 2'd1;
        model_run(3'd0, 4'd0);
        run_dut(3'd0, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0);
        n_checks++;
        if (r_timeout || r_edges !== 2) begin
            n_bad++;
            $display("FAIL left_latency: got %0d edges want 2", r_edges);
        end
        n_checks++;
        if ({done, fault, timeout, state, head, step_count} !== {1'b1, 1'b1, 1'b0, 3'd1, 4'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL left_status: got done=%0b fault=%0b to=%0b st=%0d hd=%0d steps=%0d want 1 1 0 1 0 1",
                     done, fault, timeout, state, head, step_count);
        end
        read_tape();
        n_checks++;
        if (obs_tape[0] !== 3'd5) begin
            n_bad++;
            $display("FAIL left_cell0: got %0d want 5", obs_tape[0]);
        end
    endtask

    task automatic test_timeout();
        rule_mode = 2'd2;
        model_run(3'd0, 4'd5);
        run_dut(3'd0, 4'd5, 1'b0, 4'd0, 3'd0, 1'b0);
        n_checks++;
        if (r_timeout || r_edges !== 2 * LIM || r_gap !== 0) begin
            n_bad++;
            $display("FAIL timeout_latency: got edges=%0d gap=%0d want edges=%0d gap=0", r_edges, r_gap, 2 * LIM);
        end
        n_checks++;
        if ({done, fault, timeout, state, head, step_count} !== {1'b1, 1'b0, 1'b1, 3'd0, 4'd5, 16'(LIM)}) begin
            n_bad++;
            $display("FAIL timeout_status: got done=%0b fault=%0b to=%0b st=%0d hd=%0d steps=%0d want 1 0 1 0 5 %0d",
                     done, fault, timeout, state, head, step_count, LIM);
        end
        read_tape();
        n_checks++;
        if (pack_obs() !== pack_model()) begin
            n_bad++;
            $display("FAIL timeout_tape: got %h want %h", pack_obs(), pack_model());
        end
    endtask

    task automatic test_halt_start();
        rule_mode = 2'd0;
        model_run(HALT, 4'd3);
        run_dut(HALT, 4'd3, 1'b0, 4'd0, 3'd0, 1'b0);
        n_checks++;
        if (r_timeout || r_edges !== 0 || rule_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_start_latency: got edges=%0d rv=%0b busy=%0b want 0 0 0", r_edges, rule_valid, busy);
        end
        n_checks++;
        if ({done, fault, timeout, state, head, step_count} !== {1'b1, 1'b0, 1'b0, HALT, 4'd3, 16'd0}) begin
            n_bad++;
            $display("FAIL halt_start_status: got done=%0b fault=%0b to=%0b st=%0d hd=%0d steps=%0d want 1 0 0 7 3 0",
                     done, fault, timeout, state, head, step_count);
        end
        // Restart from DONE on the retained tape.
        model_run(3'd0, 4'd2);
        run_dut(3'd0, 4'd2, 1'b0, 4'd0, 3'd0, 1'b0);
        n_checks++;
        if (r_timeout || r_edges !== 2 * e_steps || {state, head, step_count} !== {e_state, e_head, 16'(e_steps)}) begin
            n_bad++;
            $display("FAIL restart: got edges=%0d st=%0d hd=%0d steps=%0d want %0d %0d %0d %0d",
                     r_edges, state, head, step_count, 2 * e_steps, e_state, e_head, e_steps);
        end
        read_tape();
        n_checks++;
        if (pack_obs() !== pack_model()) begin
            n_bad++;
            $display("FAIL restart_tape: got %h want %h", pack_obs(), pack_model());
        end
    endtask

    task automatic test_random();
        logic [2:0] ss;
        logic [3:0] sh;
        logic [3:0] la;
        logic [2:0] ls;
        bit         ld;
        rule_mode = 2'd3;
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 64; k++) rtab[k] = 7'($urandom);
            for (int k = 0; k < 3; k++) load_cell(4'($urandom_range(0, 15)), 3'($urandom));
            ss = 3'($urandom);
            sh = 4'($urandom);
            ld = ($urandom_range(0, 2) == 0);
            la = 4'($urandom);
            ls = 3'($urandom);
            if (ld) m_tape[la] = ls;
            model_run(ss, sh);
            run_dut(ss, sh, ld, la, ls, 1'b0);
            n_checks++;
            if (r_timeout || r_edges !== 2 * e_steps || r_gap !== 0) begin
                n_bad++;
                $display("FAIL rand%0d_latency: got edges=%0d gap=%0d want edges=%0d gap=0",
                         it, r_edges, r_gap, 2 * e_steps);
            end
            n_checks++;
            if ({busy, fault, timeout, state, head, step_count} !==
                {1'b0, e_fault, e_to, e_state, e_head, 16'(e_steps)}) begin
                n_bad++;
                $display("FAIL rand%0d_status: got busy=%0b f=%0b to=%0b st=%0d hd=%0d n=%0d want 0 %0b %0b %0d %0d %0d",
                         it, busy, fault, timeout, state, head, step_count, e_fault, e_to, e_state, e_head, e_steps);
            end
            read_tape();
            n_checks++;
            if (pack_obs() !== pack_model()) begin
                n_bad++;
                $display("FAIL rand%0d_tape: got %h want %h", it, pack_obs(), pack_model());
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [33:0] obs;
        for (int i = 0; i < TL; i++) load_cell(4'(i), 3'd3);
        rule_mode = 2'd0;
        @(negedge clock);
        start       = 1'b1;
        start_state = 3'd0;
        start_head  = 4'd4;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        obs = {rule_valid, busy, done, fault, timeout, state, head, step_count, rule_state, rule_sym};
        n_checks++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got %h want 0", obs);
        end
        read_tape();
        for (int i = 0; i < TL; i++) m_tape[i] = 3'd0;
        n_checks++;
        if (pack_obs() !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset_tape: got %h want 0", pack_obs());
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rtab[k] = '0;
        for (int i = 0; i < TL; i++) m_tape[i] = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_preload();
        test_stub_run();
        test_left_edge();
        test_timeout();
        test_halt_start();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
